// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file with a per-register
// busy scoreboard and a registered pending-writeback counter.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> same-cycle write-to-read forwarding (combinational wdata->rdata path)
//   undefined -> reads return pre-clock contents; writes are visible next cycle
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NRD*$clog2(NREGS)-1:0]    raddr_i,
  output logic [NRD*XLEN-1:0]             rdata_o,
  output logic [NRD-1:0]                  rbusy_o,
  input  logic [NWR-1:0]                  we_i,
  input  logic [NWR*$clog2(NREGS)-1:0]    waddr_i,
  input  logic [NWR*XLEN-1:0]             wdata_i,
  input  logic                            rsv_valid_i,
  input  logic [$clog2(NREGS)-1:0]        rsv_addr_i,
  output logic                            rsv_ok_o,
  output logic [$clog2(NREGS):0]          pend_cnt_o
);

  localparam int AW = $clog2(NREGS);
  localparam bit ZR = (ZERO_REG != 0);

  logic [XLEN-1:0] rf_q [NREGS];
  logic [XLEN-1:0] rf_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      pend_q, pend_d;
  logic [NWR-1:0]   wr_act;

  // Effective write enables: a write to register 0 is dropped when it is hardwired.
  always_comb begin
    wr_act = '0;
    for (int j = 0; j < NWR; j++) begin
      wr_act[j] = we_i[j] && !(ZR && (waddr_i[j*AW +: AW] == '0));
    end
  end

  // Reservation acceptance uses the pre-clock busy value only.
  assign rsv_ok_o = rsv_valid_i && !busy_q[rsv_addr_i] && !(ZR && (rsv_addr_i == '0));

  // Next-state data/busy: ascending port order lets the highest port win a collision,
  // and the reservation is applied last so it wins busy over a same-cycle write.
  always_comb begin
    rf_d   = rf_q;
    busy_d = busy_q;
    for (int j = 0; j < NWR; j++) begin
      if (wr_act[j]) begin
        rf_d[waddr_i[j*AW +: AW]]   = wdata_i[j*XLEN +: XLEN];
        busy_d[waddr_i[j*AW +: AW]] = 1'b0;
      end
    end
    if (rsv_ok_o) begin
      busy_d[rsv_addr_i] = 1'b1;
    end
    if (ZR) begin
      rf_d[0]   = '0;
      busy_d[0] = 1'b0;
    end
  end

  // Population count of the next-state busy vector feeds the registered counter.
  always_comb begin
    pend_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      pend_d = pend_d + (AW+1)'(busy_d[i]);
    end
  end

  // State registers: register array, busy scoreboard and pending counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_q   <= '{default: '0};
      busy_q <= '0;
      pend_q <= '0;
    end else begin
      rf_q   <= rf_d;
      busy_q <= busy_d;
      pend_q <= pend_d;
    end
  end

  assign pend_cnt_o = pend_q;

  // Combinational read ports, with optional forwarding from the write ports.
  always_comb begin
    rdata_o = '0;
    rbusy_o = '0;
    for (int k = 0; k < NRD; k++) begin
      rdata_o[k*XLEN +: XLEN] = rf_q[raddr_i[k*AW +: AW]];
      rbusy_o[k]              = busy_q[raddr_i[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      // Forwarding is suppressed in reset so reads stay at zero while rst is high.
      for (int j = 0; j < NWR; j++) begin
        if (!rst && wr_act[j] && (waddr_i[j*AW +: AW] == raddr_i[k*AW +: AW])) begin
          rdata_o[k*XLEN +: XLEN] = wdata_i[j*XLEN +: XLEN];
          rbusy_o[k]              = rsv_ok_o && (rsv_addr_i == raddr_i[k*AW +: AW]);
        end
      end
`endif
      if (ZR && (raddr_i[k*AW +: AW] == '0)) begin
        rdata_o[k*XLEN +: XLEN] = '0;
        rbusy_o[k]              = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed table, hand-written corner sequences and a
// randomized phase checked against a behavioural model of the register file.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int AW = 5;
  localparam int NRD = 2;
  localparam int NWR = 2;

  logic                 clk, rst, clk_en;
  logic [NRD*AW-1:0]    raddr;
  logic [NRD*XLEN-1:0]  rdata;
  logic [NRD-1:0]       rbusy;
  logic [NWR-1:0]       we;
  logic [NWR*AW-1:0]    waddr;
  logic [NWR*XLEN-1:0]  wdata;
  logic                 rsv_valid;
  logic [AW-1:0]        rsv_addr;
  logic                 rsv_ok;
  logic [AW:0]          pend_cnt;

  int errors = 0;
  int checks = 0;

  // Behavioural model state.
  logic [XLEN-1:0] m_rf [NREGS];
  logic [NREGS-1:0] m_busy;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst),
    .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .rsv_valid_i(rsv_valid), .rsv_addr_i(rsv_addr),
    .rsv_ok_o(rsv_ok), .pend_cnt_o(pend_cnt)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NREGS; i++) m_rf[i] = '0;
    m_busy = '0;
  endfunction

  function automatic bit model_ok();
    return rsv_valid && !m_busy[rsv_addr] && (rsv_addr != 0);
  endfunction

  task automatic model_read(input int k, output logic [31:0] d, output logic b);
    logic [AW-1:0] a;
    a = raddr[k*AW +: AW];
    d = m_rf[a];
    b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
    for (int j = 0; j < NWR; j++) begin
      if (we[j] && waddr[j*AW +: AW] == a && a != 0) begin
        d = wdata[j*XLEN +: XLEN];
        b = model_ok() && (rsv_addr == a);
      end
    end
`endif
    if (a == 0) begin
      d = '0;
      b = 1'b0;
    end
  endtask

  // Clock-edge update of the model: later ports overwrite earlier ones,
  // then an accepted reservation marks its register busy.
  function automatic void model_clock();
    bit ok;
    ok = model_ok();
    for (int j = 0; j < NWR; j++) begin
      if (we[j] && waddr[j*AW +: AW] != 0) begin
        m_rf[waddr[j*AW +: AW]]   = wdata[j*XLEN +: XLEN];
        m_busy[waddr[j*AW +: AW]] = 1'b0;
      end
    end
    if (ok) m_busy[rsv_addr] = 1'b1;
  endfunction

  task automatic check_model(input string tag);
    logic [31:0] d;
    logic        b;
    for (int k = 0; k < NRD; k++) begin
      model_read(k, d, b);
      chk($sformatf("%s rdata%0d", tag, k), rdata[k*XLEN +: XLEN], d);
      chk($sformatf("%s rbusy%0d", tag, k), {31'b0, rbusy[k]}, {31'b0, b});
    end
    chk($sformatf("%s rsv_ok", tag), {31'b0, rsv_ok}, {31'b0, model_ok()});
    chk($sformatf("%s pend_cnt", tag), {26'b0, pend_cnt}, $countones(m_busy));
  endtask

  task automatic clock_edge();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle_inputs();
    we = '0; waddr = '0; wdata = '0; rsv_valid = 1'b0; rsv_addr = '0;
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        rv;
    logic [4:0]  ra;
    logic [4:0]  rd0;
    logic [4:0]  rd1;
    logic [31:0] e_d0;
    logic        e_b0;
    logic [31:0] e_d1;
    logic        e_b1;
    logic        e_ok;
    logic [5:0]  e_pend;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [31:0] bypass_exp;
    logic        bypass_busy;

    tbl[0]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,  1'b0, 5'd0, 5'd6, 5'd0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 6'd0};
    tbl[1]  = '{2'b01, 5'd0, 32'h1234,     5'd0, 32'h0,  1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b0, 6'd0};
    tbl[2]  = '{2'b11, 5'd7, 32'h11,       5'd7, 32'h22, 1'b0, 5'd0, 5'd0, 5'd5, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 6'd0};
    tbl[3]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b1, 5'd3, 5'd7, 5'd0, 32'h22,       1'b0, 32'h0,        1'b0, 1'b1, 6'd0};
    tbl[4]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b1, 5'd3, 5'd3, 5'd7, 32'h0,        1'b1, 32'h22,       1'b0, 1'b0, 6'd1};
    tbl[5]  = '{2'b10, 5'd0, 32'h0,        5'd3, 32'hAB, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b0, 6'd1};
    tbl[6]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b1, 5'd0, 5'd3, 5'd0, 32'hAB,       1'b0, 32'h0,        1'b0, 1'b0, 6'd0};
    tbl[7]  = '{2'b01, 5'd9, 32'h55,       5'd0, 32'h0,  1'b1, 5'd9, 5'd3, 5'd0, 32'hAB,       1'b0, 32'h0,        1'b0, 1'b1, 6'd0};
    tbl[8]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd9, 5'd3, 32'h55,       1'b1, 32'hAB,       1'b0, 1'b0, 6'd1};
    tbl[9]  = '{2'b01, 5'd9, 32'h66,       5'd0, 32'h0,  1'b1, 5'd9, 5'd5, 5'd7, 32'hDEADBEEF, 1'b0, 32'h22,       1'b0, 1'b0, 6'd1};
    tbl[10] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd9, 5'd0, 32'h66,       1'b0, 32'h0,        1'b0, 1'b0, 6'd0};

    // Reset with the clock stopped, then read every address on both ports.
    clk_en = 1'b0;
    idle_inputs();
    raddr = '0;
    rst = 1'b1;
    model_reset();
    #10;
    rst = 1'b0;
    #1;
    for (int a = 0; a < NREGS; a++) begin
      raddr = {a[4:0], a[4:0]};
      #1;
      chk($sformatf("reset rdata0 a%0d", a), rdata[31:0], 32'h0);
      chk($sformatf("reset rdata1 a%0d", a), rdata[63:32], 32'h0);
      chk($sformatf("reset rbusy a%0d", a), {30'b0, rbusy}, 32'h0);
    end
    chk("reset pend_cnt", {26'b0, pend_cnt}, 32'h0);
    chk("reset rsv_ok", {31'b0, rsv_ok}, 32'h0);
    clk_en = 1'b1;

    // Directed table.
    for (int i = 0; i < 11; i++) begin
      we        = tbl[i].we;
      waddr     = {tbl[i].wa1, tbl[i].wa0};
      wdata     = {tbl[i].wd1, tbl[i].wd0};
      rsv_valid = tbl[i].rv;
      rsv_addr  = tbl[i].ra;
      raddr     = {tbl[i].rd1, tbl[i].rd0};
      @(negedge clk);
      chk($sformatf("row%0d rdata0", i), rdata[31:0], tbl[i].e_d0);
      chk($sformatf("row%0d rbusy0", i), {31'b0, rbusy[0]}, {31'b0, tbl[i].e_b0});
      chk($sformatf("row%0d rdata1", i), rdata[63:32], tbl[i].e_d1);
      chk($sformatf("row%0d rbusy1", i), {31'b0, rbusy[1]}, {31'b0, tbl[i].e_b1});
      chk($sformatf("row%0d rsv_ok", i), {31'b0, rsv_ok}, {31'b0, tbl[i].e_ok});
      chk($sformatf("row%0d pend_cnt", i), {26'b0, pend_cnt}, {26'b0, tbl[i].e_pend});
      clock_edge();
    end

    // Same-cycle write and read of reg 4 (reg 4 never written before).
    idle_inputs();
    we = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'h0, 32'hCAFE};
    raddr = {5'd0, 5'd4};
`ifdef REGFILE_BYPASS_EN
    bypass_exp = 32'hCAFE;
`else
    bypass_exp = 32'h0;
`endif
    @(negedge clk);
    chk("bypass same-cycle rdata", rdata[31:0], bypass_exp);
    chk("bypass same-cycle rbusy", {31'b0, rbusy[0]}, 32'h0);
    clock_edge();
    idle_inputs();
    @(negedge clk);
    chk("bypass next-cycle rdata", rdata[31:0], 32'hCAFE);
    clock_edge();

    // Write plus reservation of reg 10 while reading it.
    we = 2'b01; waddr = {5'd0, 5'd10}; wdata = {32'h0, 32'h77};
    rsv_valid = 1'b1; rsv_addr = 5'd10;
    raddr = {5'd0, 5'd10};
`ifdef REGFILE_BYPASS_EN
    bypass_exp = 32'h77; bypass_busy = 1'b1;
`else
    bypass_exp = 32'h0;  bypass_busy = 1'b0;
`endif
    @(negedge clk);
    chk("bypass rsv rdata", rdata[31:0], bypass_exp);
    chk("bypass rsv rbusy", {31'b0, rbusy[0]}, {31'b0, bypass_busy});
    chk("bypass rsv rsv_ok", {31'b0, rsv_ok}, 32'h1);
    clock_edge();
    idle_inputs();
    @(negedge clk);
    chk("after rsv rdata", rdata[31:0], 32'h77);
    chk("after rsv rbusy", {31'b0, rbusy[0]}, 32'h1);
    chk("after rsv pend_cnt", {26'b0, pend_cnt}, 32'h1);
    clock_edge();

    // Reset asserted mid-operation with a write and reservation in flight.
    we = 2'b01; waddr = {5'd0, 5'd12}; wdata = {32'h0, 32'h99};
    rsv_valid = 1'b1; rsv_addr = 5'd12;
    raddr = {5'd10, 5'd5};
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst rdata0", rdata[31:0], 32'h0);
    chk("midrst rbusy1", {31'b0, rbusy[1]}, 32'h0);
    chk("midrst pend_cnt", {26'b0, pend_cnt}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    idle_inputs();
    raddr = {5'd10, 5'd12};
    #1;
    chk("postrst rdata12", rdata[31:0], 32'h0);
    chk("postrst rbusy12", {31'b0, rbusy[0]}, 32'h0);
    chk("postrst rbusy10", {31'b0, rbusy[1]}, 32'h0);
    chk("postrst pend_cnt", {26'b0, pend_cnt}, 32'h0);

    // Randomized traffic on a narrow address range to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      we        = 2'($urandom_range(0, 3));
      waddr     = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
      wdata     = {$urandom, $urandom};
      rsv_valid = 1'($urandom_range(0, 1));
      rsv_addr  = 5'($urandom_range(0, 15));
      raddr     = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
      @(negedge clk);
      check_model($sformatf("rand%0d", n));
      clock_edge();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file, successor to the single-write/dual-read CPU register file.
- Adds the following:
  - configurable width, depth, read-port and write-port counts;
  - optional hardwired-zero register 0;
  - a per-register busy scoreboard for the issue stage;
  - a registered pending-writeback counter.
- Sits between decode/issue (reads, reservations) and writeback (writes).

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, >= 2. Derived localparam AW = $clog2(NREGS).
- NRD, 2, number of read ports (1..8).
- NWR, 1, number of write ports (1..4).
- ZERO_REG, 1, if 1: register 0 reads as 0, ignores writes, and can never be busy.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- raddr  in  NRD*AW  read addresses; port k at [k*AW +: AW]
- rdata  out  NRD*XLEN  read data; port k at [k*XLEN +: XLEN]
- rbusy  out  NRD  busy bit of the register addressed by read port k
- we  in  NWR  write enables
- waddr  in  NWR*AW  write addresses
- wdata  in  NWR*XLEN  write data
- rsv_valid  in  1  reserve request: mark rsv_addr busy
- rsv_addr  in  AW  register to reserve
- rsv_ok  out  1  reservation accepted this cycle (combinational)
- pend_cnt  out  AW+1  registered count of busy registers

Behaviour:
- Reset (async, rst=1):
  - all registers <= 0; all busy bits <= 0; pend_cnt <= 0.
  - rdata/rbusy are combinational and therefore read 0 during reset.
  - Reset asserted mid-operation discards in-flight writes and reservations in that cycle.
- Reads: combinational, zero cycles.
  - rdata[k] = rf[raddr[k]] and rbusy[k] = busy[raddr[k]].
  - ZERO_REG=1 and raddr=0: returns 0 and busy 0.
- Writes: on posedge clk, for each port j with we[j]=1 (and waddr[j]!=0 when ZERO_REG=1), rf[waddr[j]] <= wdata[j] and busy[waddr[j]] <= 0.
  - Same-address write collision: the highest-index port j wins, for both data and busy clear.
  - Write to a non-busy register is legal and updates data.
- Reservation:
  - rsv_ok = rsv_valid & !busy[rsv_addr] & !(ZERO_REG && rsv_addr==0).
  - On rsv_ok, busy[rsv_addr] <= 1 at posedge.
  - Reserving a register that is being written in the same cycle: the write updates data, and the reservation wins for busy (end state busy=1). rsv_ok uses the pre-clock busy value, so an already-busy register is refused even if it is being written this cycle.
  - Refused request: no state change.
- pend_cnt: registered population count of the next-state busy vector, so it tracks busy with one cycle of latency. Range 0..NREGS (or NREGS-1 when ZERO_REG=1); no wrap possible.
- Out-of-range addresses cannot occur (NREGS power of two).

Optional Feature:
- REGFILE_BYPASS_EN defined:
  - Write-to-read forwarding. If any we[j] matches raddr[k] (excluding reg 0 when ZERO_REG=1), rdata[k] = wdata of the highest-index matching port, and rbusy[k] = 0 unless rsv_ok targets the same address, in which case rbusy[k] = 1.
  - Zero added cycles; this is a combinational path from wdata to rdata.
- Undefined: reads return the pre-clock register contents. A write becomes visible the cycle after it is presented.

Test Plan:
- Reset check: assert rst with clk stopped, release, then read all addresses on every port -> rdata=0, rbusy=0, pend_cnt=0.
- Write then read: we[0]=1, waddr=5, wdata=0xDEADBEEF; next cycle raddr[0]=5 -> 0xDEADBEEF. Write to reg 0 with 0x1234 -> reads 0 (ZERO_REG=1).
- Collision (NWR=2): both ports write reg 7, port0 data 0x11, port1 data 0x22 -> reg 7 = 0x22.
- Scoreboard:
  - reserve reg 3 -> rsv_ok=1, next cycle rbusy=1 for reg 3, pend_cnt=1;
  - reserve reg 3 again -> rsv_ok=0;
  - write reg 3 with 0xAB -> busy clears, pend_cnt=0 one cycle later;
  - reserve reg 0 -> rsv_ok=0.
- Same-cycle write and reserve on reg 9 (not previously busy), data 0x55 -> reg 9 = 0x55, busy=1, pend_cnt=1.
- Bypass:
  - with REGFILE_BYPASS_EN, write reg 4 = 0xCAFE while reading reg 4 in the same cycle -> rdata=0xCAFE that cycle;
  - without the macro -> old value that cycle, 0xCAFE the next cycle.
